// File: rtl/synapse_current_gen.sv
// Walks every neuron once per timestep. For each neuron it sums the spike-gated weights (exc) and forms
// lateral inhibition from the previous step's spikes (inh). Optional saturation is enabled by CURRENT_SAT_EN.
module synapse_current_gen #(
  parameter int          N_NEURON = 18,
  parameter int          N_INPUT  = 784,
  parameter int          W_WGT    = 16,
  parameter logic [24:0] INH_W    = 25'd65536,
  localparam int         AW       = $clog2(N_NEURON*N_INPUT),
  localparam int         NW       = (N_NEURON > 1) ? $clog2(N_NEURON) : 1,
  localparam int         IW       = (N_INPUT > 1) ? $clog2(N_INPUT) : 1,
  localparam int         PW       = $clog2(N_NEURON+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_s_init,
  input  logic [N_INPUT-1:0]  i_in_spk,
  output logic [AW-1:0]       wgt_addr,
  output logic                wgt_ce,
  input  logic [W_WGT-1:0]    wgt_q,
  output logic                o_run,
  output logic signed [24:0]  o_exc_current,
  output logic signed [24:0]  o_inh_current,
  input  logic                i_valid,
  input  logic                i_spike,
  input  logic [4:0]          i_neuron_idx,
  output logic                o_busy,
  output logic                o_step_done,
  output logic [N_NEURON-1:0] o_spk_vec
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_DRAIN = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [IW-1:0] LAST_I    = IW'(N_INPUT - 1);
  localparam logic [NW-1:0] LAST_N    = NW'(N_NEURON - 1);
  localparam logic [AW-1:0] N_INPUT_A = AW'(N_INPUT);

  function automatic logic [24:0] add_cur(input logic [24:0] a, input logic [24:0] b);
`ifdef CURRENT_SAT_EN
    logic [25:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > 26'h0FFFFFF) begin
      return 25'h0FFFFFF;
    end else begin
      return s[24:0];
    end
`else
    return a + b;
`endif
  endfunction

  function automatic logic [24:0] inh_scale(input logic [PW-1:0] cnt);
`ifdef CURRENT_SAT_EN
    logic [PW+24:0] p;
    p = {{PW{1'b0}}, INH_W} * {{25{1'b0}}, cnt};
    if (p > {{PW{1'b0}}, 25'h0FFFFFF}) begin
      return 25'h0FFFFFF;
    end else begin
      return p[24:0];
    end
`else
    logic [24:0] c;
    c = 25'(cnt);
    return INH_W * c;
`endif
  endfunction

  function automatic logic [PW-1:0] popcnt(input logic [N_NEURON-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int k = 0; k < N_NEURON; k++) begin
      c = c + PW'(v[k]);
    end
    return c;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [NW-1:0] n, input logic [IW-1:0] i);
    return AW'(n) * N_INPUT_A + AW'(i);
  endfunction

  state_t              state_q, state_d;
  logic [NW-1:0]       nidx_q, nidx_d;
  logic [IW-1:0]       iidx_q, iidx_d;
  logic [24:0]         acc_q, acc_d;
  logic [N_INPUT-1:0]  spk_in_q, spk_in_d;
  logic [N_NEURON-1:0] cur_spk_q, cur_spk_d;
  logic [N_NEURON-1:0] prev_spk_q, prev_spk_d;
  logic [N_NEURON-1:0] spk_vec_q, spk_vec_d;
  logic [24:0]         exc_q, exc_d;
  logic [24:0]         inh_q, inh_d;
  logic                rd_spk_q, rd_spk_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ce_q, ce_d;
  logic [AW-1:0]       addr_q, addr_d;

  logic [24:0]         wgt_ext;
  logic [24:0]         acc_sum;
  logic [N_NEURON-1:0] others;

  // Fold the weight returned this cycle into the running sum when its spike bit was set.
  always_comb begin
    wgt_ext = {{(25-W_WGT){1'b0}}, wgt_q};
    if (rd_spk_q) begin
      acc_sum = add_cur(acc_q, wgt_ext);
    end else begin
      acc_sum = acc_q;
    end
  end

  // Neighbours that spiked last step, excluding the neuron being served.
  always_comb begin
    others         = prev_spk_q;
    others[nidx_q] = 1'b0;
  end

  // Next-state logic for the neuron walk.
  always_comb begin
    state_d    = state_q;
    nidx_d     = nidx_q;
    iidx_d     = iidx_q;
    acc_d      = acc_q;
    spk_in_d   = spk_in_q;
    cur_spk_d  = cur_spk_q;
    prev_spk_d = prev_spk_q;
    spk_vec_d  = spk_vec_q;
    exc_d      = exc_q;
    inh_d      = inh_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_s_init) begin
          spk_in_d  = i_in_spk;
          nidx_d    = '0;
          iidx_d    = '0;
          acc_d     = '0;
          cur_spk_d = '0;
          state_d   = S_ACCUM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        acc_d = acc_sum;
        if (iidx_q == LAST_I) begin
          iidx_d  = '0;
          state_d = S_DRAIN;
        end else begin
          iidx_d = iidx_q + IW'(1);
        end
      end
      S_DRAIN: begin
        acc_d   = acc_sum;
        exc_d   = acc_sum;
        inh_d   = inh_scale(popcnt(others));
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_valid) begin
          // Out-of-range indices match no bit, so they are dropped but still advance the walk.
          for (int k = 0; k < N_NEURON; k++) begin
            cur_spk_d[k] = cur_spk_q[k] | (i_spike && (i_neuron_idx == 5'(k)));
          end
          if (nidx_q == LAST_N) begin
            spk_vec_d  = cur_spk_d;
            prev_spk_d = cur_spk_d;
            state_d    = S_DONE;
          end else begin
            nidx_d  = nidx_q + NW'(1);
            iidx_d  = '0;
            acc_d   = '0;
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        nidx_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output registers are loaded from the next state so each pulse lines up with its state.
  always_comb begin
    rd_spk_d = (state_q == S_ACCUM) && spk_in_q[iidx_q];
    run_d    = (state_d == S_ISSUE);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
    ce_d     = (state_d == S_ACCUM);
    if (ce_d) begin
      addr_d = addr_of(nidx_d, iidx_d);
    end else begin
      addr_d = '0;
    end
  end

  // State and output registers; reset clears everything including last step's spikes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nidx_q     <= '0;
      iidx_q     <= '0;
      acc_q      <= '0;
      spk_in_q   <= '0;
      cur_spk_q  <= '0;
      prev_spk_q <= '0;
      spk_vec_q  <= '0;
      exc_q      <= '0;
      inh_q      <= '0;
      rd_spk_q   <= 1'b0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ce_q       <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      nidx_q     <= nidx_d;
      iidx_q     <= iidx_d;
      acc_q      <= acc_d;
      spk_in_q   <= spk_in_d;
      cur_spk_q  <= cur_spk_d;
      prev_spk_q <= prev_spk_d;
      spk_vec_q  <= spk_vec_d;
      exc_q      <= exc_d;
      inh_q      <= inh_d;
      rd_spk_q   <= rd_spk_d;
      run_q      <= run_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ce_q       <= ce_d;
      addr_q     <= addr_d;
    end
  end

  assign wgt_addr      = addr_q;
  assign wgt_ce        = ce_q;
  assign o_run         = run_q;
  assign o_exc_current = exc_q;
  assign o_inh_current = inh_q;
  assign o_busy        = busy_q;
  assign o_step_done   = done_q;
  assign o_spk_vec     = spk_vec_q;

endmodule

// File: tb/tb_synapse_current_gen.sv
// Bench for synapse_current_gen: randomized timesteps are checked against an arithmetic reference.
// A second, wide instance exercises overflow of the excitatory sum.
module tb_synapse_current_gen;
  localparam int NN = 4;
  localparam int NI = 8;
  localparam int BI = 260;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               i_start = 1'b0;
  logic               i_s_init = 1'b0;
  logic [NI-1:0]      i_in_spk = '0;
  logic [4:0]         wgt_addr;
  logic               wgt_ce;
  logic [15:0]        wgt_q = '0;
  logic               o_run;
  logic signed [24:0] o_exc_current, o_inh_current;
  logic               i_valid = 1'b0;
  logic               i_spike = 1'b0;
  logic [4:0]         i_neuron_idx = '0;
  logic               o_busy, o_step_done;
  logic [NN-1:0]      o_spk_vec;

  logic               b_start = 1'b0;
  logic [BI-1:0]      b_in_spk = '1;
  logic [9:0]         b_addr;
  logic               b_ce;
  logic [15:0]        b_wgt = '0;
  logic               b_run;
  logic signed [24:0] b_exc, b_inh;
  logic               b_valid = 1'b0;
  logic [4:0]         b_idx = '0;
  logic               b_busy, b_done;
  logic [1:0]         b_spk_vec;

  synapse_current_gen #(.N_NEURON(NN), .N_INPUT(NI)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_s_init(i_s_init), .i_in_spk(i_in_spk),
    .wgt_addr(wgt_addr), .wgt_ce(wgt_ce), .wgt_q(wgt_q), .o_run(o_run),
    .o_exc_current(o_exc_current), .o_inh_current(o_inh_current), .i_valid(i_valid),
    .i_spike(i_spike), .i_neuron_idx(i_neuron_idx), .o_busy(o_busy),
    .o_step_done(o_step_done), .o_spk_vec(o_spk_vec)
  );

  synapse_current_gen #(.N_NEURON(2), .N_INPUT(BI)) dut_big (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_s_init(1'b0), .i_in_spk(b_in_spk),
    .wgt_addr(b_addr), .wgt_ce(b_ce), .wgt_q(b_wgt), .o_run(b_run),
    .o_exc_current(b_exc), .o_inh_current(b_inh), .i_valid(b_valid),
    .i_spike(1'b0), .i_neuron_idx(b_idx), .o_busy(b_busy),
    .o_step_done(b_done), .o_spk_vec(b_spk_vec)
  );

  logic [15:0]   mem [NN*NI];
  logic [NN-1:0] prev_model = '0;
  int            n_cmp = 0;
  int            n_mis = 0;

  always @(posedge clk) begin
    if (wgt_ce) wgt_q <= mem[wgt_addr];
    if (b_ce) b_wgt <= (b_addr < 10'd520) ? 16'hFFFF : 16'h0000;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [24:0] fold(input longint s);
`ifdef CURRENT_SAT_EN
    return (s > 64'h0FFFFFF) ? 25'h0FFFFFF : 25'(s);
`else
    return 25'(s);
`endif
  endfunction

  function automatic logic [24:0] exp_exc(input int n, input logic [NI-1:0] spk);
    longint s = 0;
    for (int i = 0; i < NI; i++) if (spk[i]) s += longint'(mem[n*NI+i]);
    return fold(s);
  endfunction

  function automatic logic [24:0] exp_inh(input int n);
    longint c = 0;
    for (int k = 0; k < NN; k++) if (k != n && prev_model[k]) c++;
    return fold(65536 * c);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    #1;
    check_eq("reset_ctl", {26'd0, o_run, o_busy, o_step_done, wgt_ce, b_busy, b_run}, 32'd0);
    check_eq("reset_vec", {23'd0, o_spk_vec, wgt_addr}, 32'd0);
    check_eq("reset_exc", {7'd0, o_exc_current}, 32'd0);
    check_eq("reset_inh", {7'd0, o_inh_current}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_model = '0;
  endtask

  // One timestep: fire = spikes reported, badidx = neurons answered with an out-of-range index.
  task automatic run_step(input logic [NI-1:0] in_spk, input logic [NN-1:0] fire,
                          input logic [NN-1:0] badidx, input int abort_n,
                          input bit extra_start, input bit check_lat);
    logic [24:0]   ee [NN];
    logic [24:0]   ei [NN];
    logic [NN-1:0] exp_vec;
    int runs = 0, valids = 0, dones = 0, cyc = 1, dly = 0, ab = 0, nid;
    bit pend = 0;
    for (int n = 0; n < NN; n++) begin
      ee[n] = exp_exc(n, in_spk);
      ei[n] = exp_inh(n);
    end
    exp_vec = fire & ~badidx;
    i_in_spk = in_spk;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_in_spk = NI'($urandom);
    while (cyc < 400) begin
      i_valid = 1'b0;
      i_spike = 1'b0;
      i_start = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          nid = runs - 1;
          i_valid = 1'b1;
          if (badidx[nid]) begin
            i_neuron_idx = 5'(NN + $urandom_range(0, 27));
            i_spike = 1'b1;
          end else begin
            i_neuron_idx = 5'(nid);
            i_spike = fire[nid];
          end
          if (extra_start && runs == 2) begin
            i_start = 1'b1;
            i_in_spk = ~in_spk;
          end
          valids++;
          pend = 0;
        end else begin
          dly--;
        end
      end else if (cyc == 3) begin
        i_valid = 1'b1;
        i_spike = 1'b1;
        i_neuron_idx = 5'($urandom_range(0, NN-1));
      end
      if (abort_n > 0 && valids == abort_n) begin
        ab++;
        if (ab == 5) begin
          do_reset();
          return;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (o_run) begin
        if (runs < NN) begin
          check_eq($sformatf("exc_n%0d", runs), {7'd0, o_exc_current}, {7'd0, ee[runs]});
          check_eq($sformatf("inh_n%0d", runs), {7'd0, o_inh_current}, {7'd0, ei[runs]});
        end
        check_eq("busy_run", {31'd0, o_busy}, 32'd1);
        if (runs == 0 && check_lat) check_eq("run_latency", cyc, 32'd10);
        runs++;
        pend = 1;
        dly = $urandom_range(1, 4);
      end
      if (o_step_done) begin
        dones++;
        check_eq("spk_vec", {28'd0, o_spk_vec}, {28'd0, exp_vec});
      end else if (dones > 0) begin
        break;
      end
    end
    check_eq("run_count", runs, NN);
    check_eq("step_done_count", dones, 32'd1);
    check_eq("busy_after", {31'd0, o_busy}, 32'd0);
    prev_model = exp_vec;
  endtask

  // Overflow case on the wide instance: every weight 16'hFFFF, every input spiking.
  task automatic run_big();
    int runs = 0, dones = 0, pend = 0;
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    for (int c = 0; c < 1500 && dones == 0; c++) begin
      b_valid = (pend == 1);
      b_idx = 5'(runs - 1);
      if (pend > 0) pend--;
      @(posedge clk);
      #1;
      if (b_run) begin
        check_eq($sformatf("big_exc_n%0d", runs), {7'd0, b_exc}, {7'd0, fold(longint'(BI) * 65535)});
        check_eq($sformatf("big_inh_n%0d", runs), {7'd0, b_inh}, 32'd0);
        runs++;
        pend = 2;
      end
      if (b_done) begin
        dones++;
        check_eq("big_spk_vec", {30'd0, b_spk_vec}, 32'd0);
      end
    end
    b_valid = 1'b0;
    check_eq("big_runs", runs, 32'd2);
    check_eq("big_done", dones, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", {31'd0, o_busy}, 32'd0);
    check_eq("reset_outs", {22'd0, o_run, o_step_done, o_spk_vec, wgt_ce, 3'd0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < NN*NI; k++) mem[k] = 16'd100;
    run_step(8'b0000_0101, 4'b0000, 4'b0000, -1, 1'b0, 1'b1);

    for (int k = 0; k < NN*NI; k++) mem[k] = 16'(k);
    run_step(8'hFF, 4'b0110, 4'b0000, -1, 1'b0, 1'b1);
    run_step(8'hFF, 4'b0000, 4'b0000, -1, 1'b1, 1'b0);

    i_s_init = 1'b1;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_s_init = 1'b0;
    check_eq("sinit_block0", {31'd0, o_busy}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("sinit_block1", {28'd0, o_busy, o_run, wgt_ce, o_step_done}, 32'd0);

    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < NN*NI; k++) mem[k] = 16'($urandom);
      run_step(NI'($urandom), NN'($urandom), NN'($urandom_range(0, 3) == 0 ? $urandom : 0),
               -1, 1'b0, 1'b1);
    end

    run_step(NI'($urandom), 4'b1111, 4'b0000, -1, 1'b0, 1'b0);
    run_step(8'hFF, 4'b1010, 4'b0000, 2, 1'b0, 1'b0);
    check_eq("post_reset_busy", {31'd0, o_busy}, 32'd0);
    run_step(8'hFF, 4'b0001, 4'b0000, -1, 1'b0, 1'b1);

    run_big();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
